// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one block-wide memory port between the I-cache and D-cache.
// A granted request is registered onto the memory port; read data returns with a one-cycle ready pulse.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;

  logic i_req, d_req, grant_side;

  assign i_req = i_mem_read | i_mem_write;
  assign d_req = d_mem_read | d_mem_write;
  // A tie goes to whichever side did not win last time.
  assign grant_side = (i_req && d_req) ? ~last_grant_q : d_req;

  always_comb begin
    // NOTE: every _d starts from its _q (or an explicit pulse default), so no path leaves a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_ready_d    = 1'b0;
    d_ready_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          last_grant_d = grant_side;
          state_d      = S_BUSY;
          // Write wins when a requester raises both strobes.
          if (grant_side == SIDE_D) begin
            mem_write_d = d_mem_write;
            mem_read_d  = d_mem_read & ~d_mem_write;
            mem_addr_d  = d_mem_addr;
            mem_wdata_d = d_mem_wdata;
          end else begin
            mem_write_d = i_mem_write;
            mem_read_d  = i_mem_read & ~i_mem_write;
            mem_addr_d  = i_mem_addr;
            mem_wdata_d = i_mem_wdata;
          end
        end
      end
      S_BUSY: begin
        if (mem_ready) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = S_RESP;
          if (last_grant_q == SIDE_D) begin
            d_ready_d = 1'b1;
            if (mem_read_q) d_rdata_d = mem_rdata;
          end else begin
            i_ready_d = 1'b1;
            if (mem_read_q) i_rdata_d = mem_rdata;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= SIDE_I;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_ready_q    <= i_ready_d;
      d_ready_q    <= d_ready_d;
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign i_mem_rdata = i_rdata_q;
  assign d_mem_rdata = d_rdata_q;
  assign i_mem_ready = i_ready_q;
  assign d_mem_ready = d_ready_q;

endmodule
